// File: rtl/ft_pkg.sv
// Shared types and default timing constants for the rollback controller.
package ft_pkg;

    localparam int unsigned CKPT_INTERVAL_DEF = 16;
    localparam int unsigned DRAIN_CYCLES_DEF  = 4;
    localparam int unsigned RST_CYCLES_DEF    = 2;
    localparam int unsigned MAX_RETRIES_DEF   = 3;

    typedef logic [31:0] addr_t;

    typedef enum logic [2:0] {
        RUN,
        HALT,
        CORE_RST,
        RESTORE,
        FAIL
    } rb_state_t;

endpackage

// File: rtl/ckpt_counter.sv
// Modulo-LIMIT event counter; tc_o flags the enabled cycle that wraps it to 0.
module ckpt_counter #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned W    = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, wrap at LAST, otherwise advance when enabled
    always_comb begin
        tc_o  = en_i && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tc_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rollback_ctrl.sv
// Checkpoint/rollback controller in front of the saved-PC register.
// Outputs are registered from the current state, so they trail the state by one cycle.
module rollback_ctrl
    import ft_pkg::*;
#(
    parameter int unsigned CKPT_INTERVAL = CKPT_INTERVAL_DEF,
    parameter int unsigned DRAIN_CYCLES  = DRAIN_CYCLES_DEF,
    parameter int unsigned RST_CYCLES    = RST_CYCLES_DEF,
    parameter int unsigned MAX_RETRIES   = MAX_RETRIES_DEF,
    localparam int unsigned RW           = $clog2(MAX_RETRIES + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          error_i,
    input  logic          commit_i,
    input  addr_t         pc_i,
    input  addr_t         spc_i,
    output logic          save_o,
    output addr_t         pc_save_o,
    output logic          halt_o,
    output logic          core_rst_n_o,
    output addr_t         boot_addr_o,
    output logic          redirect_o,
    output logic          recovering_o,
    output logic [RW-1:0] retry_cnt_o,
    output logic          fail_o
);

    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    rb_state_t     state_q, state_d;
    logic [RW-1:0] retry_q, retry_d;
    addr_t         pc_save_q, pc_save_d;
    addr_t         boot_q, boot_d;
    logic          save_q, save_d;
    logic          halt_q, halt_d;
    logic          core_rst_n_q, core_rst_n_d;
    logic          redirect_q, redirect_d;
    logic          recovering_q, recovering_d;
    logic          fail_q, fail_d;

    logic commit_en, commit_tc, drain_tc, rst_tc;

    // An error in the same cycle suppresses the commit entirely
    assign commit_en = (state_q == RUN) && commit_i && !error_i;

    ckpt_counter #(.LIMIT(CKPT_INTERVAL)) u_commit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (state_q == RESTORE),
        .en_i  (commit_en),
        .tc_o  (commit_tc)
    );

    ckpt_counter #(.LIMIT(DRAIN_CYCLES)) u_drain_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (state_q != HALT),
        .en_i  (state_q == HALT),
        .tc_o  (drain_tc)
    );

    ckpt_counter #(.LIMIT(RST_CYCLES)) u_rst_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (state_q != CORE_RST),
        .en_i  (state_q == CORE_RST),
        .tc_o  (rst_tc)
    );

    // Next-state, datapath updates and output decode
    always_comb begin
        state_d      = state_q;
        retry_d      = retry_q;
        pc_save_d    = pc_save_q;
        boot_d       = boot_q;
        save_d       = commit_tc;
        halt_d       = state_q inside {HALT, CORE_RST, FAIL};
        core_rst_n_d = !(state_q inside {CORE_RST, FAIL});
        redirect_d   = (state_q == RESTORE);
        recovering_d = state_q inside {HALT, CORE_RST, RESTORE};
        fail_d       = (state_q == FAIL);
        case (state_q)
            RUN: begin
                if (error_i) begin
                    state_d = (retry_q == RETRY_MAX) ? FAIL : HALT;
                end else if (commit_i) begin
                    pc_save_d = pc_i;
                    if (commit_tc) begin
                        retry_d = '0;
                    end
                end
            end
            HALT: begin
                if (drain_tc) begin
                    state_d = CORE_RST;
                    boot_d  = spc_i;
                end
            end
            CORE_RST: begin
                if (rst_tc) begin
                    state_d = RESTORE;
                end
            end
            RESTORE: begin
                state_d = RUN;
                if (retry_q != RETRY_MAX) begin
                    retry_d = retry_q + 1'b1;
                end
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State and registered outputs; reset releases the core immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            retry_q      <= '0;
            pc_save_q    <= '0;
            boot_q       <= '0;
            save_q       <= 1'b0;
            halt_q       <= 1'b0;
            core_rst_n_q <= 1'b1;
            redirect_q   <= 1'b0;
            recovering_q <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            retry_q      <= retry_d;
            pc_save_q    <= pc_save_d;
            boot_q       <= boot_d;
            save_q       <= save_d;
            halt_q       <= halt_d;
            core_rst_n_q <= core_rst_n_d;
            redirect_q   <= redirect_d;
            recovering_q <= recovering_d;
            fail_q       <= fail_d;
        end
    end

    assign save_o       = save_q;
    assign pc_save_o    = pc_save_q;
    assign halt_o       = halt_q;
    assign core_rst_n_o = core_rst_n_q;
    assign boot_addr_o  = boot_q;
    assign redirect_o   = redirect_q;
    assign recovering_o = recovering_q;
    assign retry_cnt_o  = retry_q;
    assign fail_o       = fail_q;

endmodule

// File: tb/tb_rollback_ctrl.sv
// Table-driven bench for rollback_ctrl plus hand sequences for reset corner cases.
module tb_rollback_ctrl;

    typedef struct {
        logic        err;
        logic        commit;
        logic [31:0] pc;
        logic [31:0] spc;
        logic        save;
        logic [31:0] pcs;
        logic        halt;
        logic        rstn;
        logic        redir;
        logic        rec;
        logic        fail;
        logic [1:0]  retry;
        logic [31:0] boot;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        error_i = 1'b0;
    logic        commit_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic [31:0] spc_i = '0;
    logic        save_o, halt_o, core_rst_n_o, redirect_o, recovering_o, fail_o;
    logic [31:0] pc_save_o, boot_addr_o;
    logic [1:0]  retry_cnt_o;

    logic        d1_err = 1'b0;
    logic        d1_save, d1_halt, d1_rstn, d1_redir, d1_rec, d1_fail;
    logic [31:0] d1_pcs, d1_boot;
    logic [1:0]  d1_retry;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    vec_t        tbl[$];
    logic [31:0] x_pcs = '0, x_boot = '0, x_spc = '0, x1_pcs = '0;
    logic [1:0]  x_retry = '0;

    always #5 clk = ~clk;

    rollback_ctrl #(.CKPT_INTERVAL(16), .DRAIN_CYCLES(4), .RST_CYCLES(2), .MAX_RETRIES(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .error_i(error_i), .commit_i(commit_i), .pc_i(pc_i), .spc_i(spc_i),
        .save_o(save_o), .pc_save_o(pc_save_o), .halt_o(halt_o), .core_rst_n_o(core_rst_n_o),
        .boot_addr_o(boot_addr_o), .redirect_o(redirect_o), .recovering_o(recovering_o),
        .retry_cnt_o(retry_cnt_o), .fail_o(fail_o)
    );

    rollback_ctrl #(.CKPT_INTERVAL(1), .DRAIN_CYCLES(4), .RST_CYCLES(2), .MAX_RETRIES(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .error_i(d1_err), .commit_i(commit_i), .pc_i(pc_i), .spc_i(spc_i),
        .save_o(d1_save), .pc_save_o(d1_pcs), .halt_o(d1_halt), .core_rst_n_o(d1_rstn),
        .boot_addr_o(d1_boot), .redirect_o(d1_redir), .recovering_o(d1_rec),
        .retry_cnt_o(d1_retry), .fail_o(d1_fail)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic err, input logic commit, input logic [31:0] pc, input logic save,
                        input logic halt, input logic rstn, input logic redir, input logic rec,
                        input logic fail);
        vec_t v;
        v.err = err;  v.commit = commit; v.pc = pc; v.spc = x_spc;
        v.save = save; v.pcs = x_pcs; v.halt = halt; v.rstn = rstn; v.redir = redir;
        v.rec = rec; v.fail = fail; v.retry = x_retry; v.boot = x_boot;
        tbl.push_back(v);
    endtask

    task automatic idle();
        push(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic commits(input logic [31:0] base, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            x_pcs = base + 32'(4 * i);
            if (i == 15) x_retry = '0;
            push(1'b0, 1'b1, x_pcs, i == 15, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        if (n == 16) x_spc = x_pcs;
    endtask

    task automatic recover(input logic commit_on_err, input logic [31:0] pc);
        push(1'b1, commit_on_err, pc, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int unsigned k = 1; k <= 4; k++) begin
            if (k == 4) x_boot = x_spc;
            push(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        for (int unsigned k = 5; k <= 6; k++) begin
            push(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        x_retry = x_retry + 2'd1;
        push(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        commits(32'h100, 16);
        idle();
        recover(1'b0, '0);
        commits(32'h200, 15);
        recover(1'b1, 32'h23C);
        commits(32'h300, 16);
        idle();
        recover(1'b0, '0);
        recover(1'b0, '0);
        recover(1'b0, '0);
        push(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        push(1'b1, 1'b1, 32'h400, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        push(1'b0, 1'b1, 32'h404, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        push(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        push(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        #1 rst_n = 1'b0;
        #2;
        chk("rst save", save_o, 0);
        chk("rst halt", halt_o, 0);
        chk("rst core_rst_n", core_rst_n_o, 1);
        chk("rst redirect", redirect_o, 0);
        chk("rst recovering", recovering_o, 0);
        chk("rst fail", fail_o, 0);
        chk("rst retry", retry_cnt_o, 0);
        chk("rst pc_save", pc_save_o, 0);
        chk("rst boot", boot_addr_o, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            error_i  = tbl[i].err;
            commit_i = tbl[i].commit;
            pc_i     = tbl[i].pc;
            spc_i    = tbl[i].spc;
            step();
            chk($sformatf("r%0d save", i), save_o, tbl[i].save);
            chk($sformatf("r%0d pc_save", i), pc_save_o, tbl[i].pcs);
            chk($sformatf("r%0d halt", i), halt_o, tbl[i].halt);
            chk($sformatf("r%0d core_rst_n", i), core_rst_n_o, tbl[i].rstn);
            chk($sformatf("r%0d redirect", i), redirect_o, tbl[i].redir);
            chk($sformatf("r%0d recovering", i), recovering_o, tbl[i].rec);
            chk($sformatf("r%0d fail", i), fail_o, tbl[i].fail);
            chk($sformatf("r%0d retry", i), retry_cnt_o, tbl[i].retry);
            chk($sformatf("r%0d boot", i), boot_addr_o, tbl[i].boot);
            if (tbl[i].commit) x1_pcs = tbl[i].pc;
            chk($sformatf("r%0d i1 save", i), d1_save, tbl[i].commit);
            chk($sformatf("r%0d i1 pc_save", i), d1_pcs, x1_pcs);
        end
        error_i = 1'b0; commit_i = 1'b0; pc_i = '0;
        chk("i1 halt", d1_halt, 0);
        chk("i1 core_rst_n", d1_rstn, 1);
        chk("i1 redirect", d1_redir, 0);
        chk("i1 recovering", d1_rec, 0);
        chk("i1 fail", d1_fail, 0);
        chk("i1 retry", d1_retry, 0);
        chk("i1 boot", d1_boot, 0);

        // Only reset leaves FAIL
        rst_n = 1'b0;
        spc_i = '0;
        #1;
        chk("failrst fail", fail_o, 0);
        chk("failrst core_rst_n", core_rst_n_o, 1);
        chk("failrst halt", halt_o, 0);
        chk("failrst retry", retry_cnt_o, 0);
        chk("failrst pc_save", pc_save_o, 0);
        step();
        rst_n = 1'b1;

        // Error before any checkpoint, then reset in the middle of CORE_RST
        error_i = 1'b1;
        step();
        error_i = 1'b0;
        repeat (5) step();
        chk("midrst pre core_rst_n", core_rst_n_o, 0);
        chk("midrst pre halt", halt_o, 1);
        chk("midrst pre recovering", recovering_o, 1);
        chk("midrst pre boot", boot_addr_o, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst core_rst_n", core_rst_n_o, 1);
        chk("midrst halt", halt_o, 0);
        chk("midrst recovering", recovering_o, 0);
        chk("midrst redirect", redirect_o, 0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("post%0d halt", k), halt_o, 0);
            chk($sformatf("post%0d recovering", k), recovering_o, 0);
            chk($sformatf("post%0d redirect", k), redirect_o, 0);
        end

        // Fresh recovery from RUN after reset: redirect exactly 7 edges later
        error_i = 1'b1;
        step();
        error_i = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("lat%0d redirect", k), redirect_o, (k == 7) ? 1 : 0);
        end
        chk("lat retry", retry_cnt_o, 1);
        chk("lat boot", boot_addr_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
